aes_share_streamer: RTL and testbench

Front-end transmitter for the round-based masked AES core (`full_AES`). It accepts a full two-share plaintext and key in parallel, then drives the core's serial load interface: a one-cycle `go` pulse, followed by 16 beats of 16-bit `pt_shared` / `key_shared`. After streaming, it holds off new requests until the core reports `done`, or until a watchdog expires. It sits between the host/register interface and `full_AES`; it is the sending end of the core's share-loading protocol.

---
 rtl/aes_share_streamer_if.sv | 29 ++
 rtl/aes_share_streamer.sv | 128 ++++++++++++
 tb/tb_aes_share_streamer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/aes_share_streamer_if.sv
// Host-side bundle for aes_share_streamer: parallel share request in,
// serial share beats and status out. Signal names follow the core's protocol.
interface aes_share_streamer_if #(
    parameter int BEAT_W = 16,
    parameter int BEATS  = 16
);
    logic                      start;
    logic [BEAT_W*BEATS-1:0]   pt_in;
    logic [BEAT_W*BEATS-1:0]   key_in;
    logic                      aes_done;
    logic                      ready;
    logic                      go;
    logic [BEAT_W-1:0]         pt_shared;
    logic [BEAT_W-1:0]         key_shared;
    logic                      busy;
    logic                      timeout;

    // Host / testbench side
    modport master (
        output start, pt_in, key_in, aes_done,
        input  ready, go, pt_shared, key_shared, busy, timeout
    );

    // Streamer side
    modport slave (
        input  start, pt_in, key_in, aes_done,
        output ready, go, pt_shared, key_shared, busy, timeout
    );
endinterface

// File: rtl/aes_share_streamer.sv
// Share-loading transmitter for the masked AES core: captures a two-share
// plaintext/key, pulses go, streams BEATS beats MSB first, then waits for
// done from the core with a watchdog.
module aes_share_streamer #(
    parameter int BEAT_W   = 16,
    parameter int BEATS    = 16,
    parameter int WAIT_MAX = 1023
) (
    input  logic                 clk,
    input  logic                 reset,   // asynchronous, active low
    aes_share_streamer_if.slave  bus
);
    localparam int DATA_W = BEAT_W * BEATS;
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
    localparam logic [WCNT_W-1:0] WAIT_LIM  = WCNT_W'(WAIT_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GO,
        S_STREAM,
        S_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_pt_reg;
    logic [DATA_W-1:0]   r_key_reg;
    logic [BCNT_W-1:0]   r_beat;
    logic [WCNT_W-1:0]   r_wait;
    logic [BEAT_W-1:0]   r_pt_shared;
    logic [BEAT_W-1:0]   r_key_shared;
    logic                r_timeout;
    logic                w_expire;
    logic                w_last_beat;
    int unsigned         w_idx;
    logic [BEAT_W-1:0]   w_pt_word;
    logic [BEAT_W-1:0]   w_key_word;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic and watchdog expiry (aes_done has priority over expiry)
    always_comb begin
        w_state_nxt = r_state;
        w_last_beat = (r_beat == LAST_BEAT);
        w_expire    = (r_state == S_WAIT) && !bus.aes_done && (r_wait == WAIT_LIM);
        case (r_state)
            S_IDLE:   if (bus.start) w_state_nxt = S_GO;
            S_GO:     w_state_nxt = S_STREAM;
            S_STREAM: if (w_last_beat) w_state_nxt = S_WAIT;
            S_WAIT:   if (bus.aes_done || w_expire) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Beat registers are loaded one cycle ahead, so select the beat that
    // will be on the outputs during the next cycle.
    always_comb begin
        w_idx = 0;
        if (r_state == S_STREAM && !w_last_beat) w_idx = 32'(r_beat) + 32'd1;
        w_pt_word  = BEAT_W'(r_pt_reg  >> (BEAT_W * (BEATS - 1 - w_idx)));
        w_key_word = BEAT_W'(r_key_reg >> (BEAT_W * (BEATS - 1 - w_idx)));
    end

    // Capture registers, counters, registered beat outputs and timeout pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pt_reg     <= '0;
            r_key_reg    <= '0;
            r_beat       <= '0;
            r_wait       <= '0;
            r_pt_shared  <= '0;
            r_key_shared <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_pt_reg  <= bus.pt_in;
                        r_key_reg <= bus.key_in;
                    end
                    r_beat       <= '0;
                    r_wait       <= '0;
                    r_pt_shared  <= '0;
                    r_key_shared <= '0;
                end
                S_GO: begin
                    r_beat       <= '0;
                    r_pt_shared  <= w_pt_word;
                    r_key_shared <= w_key_word;
                end
                S_STREAM: begin
                    if (w_last_beat) begin
                        r_wait       <= '0;
                        r_pt_shared  <= '0;
                        r_key_shared <= '0;
                    end else begin
                        r_beat       <= r_beat + BCNT_W'(1);
                        r_pt_shared  <= w_pt_word;
                        r_key_shared <= w_key_word;
                    end
                end
                S_WAIT: begin
                    if (!bus.aes_done && r_wait != WAIT_LIM) r_wait <= r_wait + WCNT_W'(1);
                    r_pt_shared  <= '0;
                    r_key_shared <= '0;
                end
                default: begin
                    r_pt_shared  <= '0;
                    r_key_shared <= '0;
                end
            endcase
        end
    end

    assign bus.ready      = (r_state == S_IDLE);
    assign bus.go         = (r_state == S_GO);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.timeout    = r_timeout;
    assign bus.pt_shared  = r_pt_shared;
    assign bus.key_shared = r_key_shared;
endmodule

// File: tb/tb_aes_share_streamer.sv
// Directed bench for aes_share_streamer with a short watchdog (WAIT_MAX=8).
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_aes_share_streamer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    aes_share_streamer_if #(.BEAT_W(16), .BEATS(16)) bus ();

    aes_share_streamer #(
        .BEAT_W(16),
        .BEATS(16),
        .WAIT_MAX(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [255:0] pat = 256'h0000111122223333444455556666777788889999AAAABBBBCCCCDDDDEEEEFFFF;
    logic [255:0] alt = {8{32'hDEADBEEF}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
        chk({tag, "_go"}, 32'(bus.go), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
        chk({tag, "_pt"}, 32'(bus.pt_shared), 32'd0);
        chk({tag, "_key"}, 32'(bus.key_shared), 32'd0);
    endtask

    // Issue one load and check go plus every beat. poke_at: beat index at
    // which a stray start with different data is raised (-1 none).
    // abort_after: beat index after which reset is pulsed (-1 none).
    // Without abort, returns at the negedge of the first WAIT cycle.
    task automatic load(input string tag, input logic [255:0] p, input logic [255:0] k,
                        input int poke_at, input int abort_after);
        @(negedge clk);
        chk({tag, "_ready_pre"}, 32'(bus.ready), 32'd1);
        bus.start  = 1'b1;
        bus.pt_in  = p;
        bus.key_in = k;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_go"}, 32'(bus.go), 32'd1);
        chk({tag, "_go_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_go_ready"}, 32'(bus.ready), 32'd0);
        chk({tag, "_go_pt"}, 32'(bus.pt_shared), 32'd0);
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk($sformatf("%s_b%0d_go", tag, b), 32'(bus.go), 32'd0);
            chk($sformatf("%s_b%0d_pt", tag, b), 32'(bus.pt_shared), 32'(p[255-16*b -: 16]));
            chk($sformatf("%s_b%0d_key", tag, b), 32'(bus.key_shared), 32'(k[255-16*b -: 16]));
            chk($sformatf("%s_b%0d_ready", tag, b), 32'(bus.ready), 32'd0);
            if (b == poke_at) begin
                bus.start  = 1'b1;
                bus.pt_in  = alt;
                bus.key_in = ~alt;
            end
            if (b == abort_after) begin
                #2 reset = 1'b0;
                #1 idle_outs({tag, "_async_rst"});
                @(negedge clk);
                idle_outs({tag, "_in_rst"});
                reset = 1'b1;
                @(negedge clk);
                idle_outs({tag, "_after_rst"});
                return;
            end
        end
        @(negedge clk);
        chk({tag, "_wait_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_wait_ready"}, 32'(bus.ready), 32'd0);
        chk({tag, "_wait_pt"}, 32'(bus.pt_shared), 32'd0);
        chk({tag, "_wait_key"}, 32'(bus.key_shared), 32'd0);
        chk({tag, "_wait_go"}, 32'(bus.go), 32'd0);
    endtask

    // Pulse aes_done in the current WAIT cycle and check the return to IDLE.
    task automatic finish_done(input string tag);
        bus.aes_done = 1'b1;
        @(negedge clk);
        bus.aes_done = 1'b0;
        chk({tag, "_done_ready"}, 32'(bus.ready), 32'd1);
        chk({tag, "_done_timeout"}, 32'(bus.timeout), 32'd0);
        chk({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        idle_outs({tag, "_idle"});
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.pt_in    = '0;
        bus.key_in   = '0;
        bus.aes_done = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        idle_outs("rst");
        reset = 1'b1;
        @(negedge clk);
        idle_outs("post_rst");

        // All-zero load
        load("zero", '0, '0, -1, -1);
        finish_done("zero");

        // Beat ordering, stray starts during STREAM and WAIT
        load("order", pat, ~pat, 2, -1);
        @(negedge clk);
        chk("order_w1_ready", 32'(bus.ready), 32'd0);
        bus.start = 1'b1;
        bus.pt_in = alt;
        @(negedge clk);
        bus.start = 1'b0;
        chk("order_w2_go", 32'(bus.go), 32'd0);
        chk("order_w2_ready", 32'(bus.ready), 32'd0);
        @(negedge clk);
        chk("order_w3_go", 32'(bus.go), 32'd0);
        chk("order_w3_busy", 32'(bus.busy), 32'd1);
        finish_done("order");

        // Async reset after beat 7, then a complete fresh load
        load("abort", pat, ~pat, -1, 7);
        load("fresh", ~pat, pat, -1, -1);
        finish_done("fresh");

        // Watchdog: WAIT entered at this negedge, timeout 9 cycles later
        load("wdog", alt, pat, -1, -1);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk($sformatf("wdog_c%0d_timeout", j), 32'(bus.timeout), 32'd0);
            chk($sformatf("wdog_c%0d_ready", j), 32'(bus.ready), 32'd0);
        end
        @(negedge clk);
        chk("wdog_c9_timeout", 32'(bus.timeout), 32'd1);
        chk("wdog_c9_ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        idle_outs("wdog_after");

        // aes_done on the expiry cycle wins: no timeout pulse
        load("race", pat, alt, -1, -1);
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            chk($sformatf("race_c%0d_timeout", j), 32'(bus.timeout), 32'd0);
        end
        @(negedge clk);
        chk("race_c8_ready", 32'(bus.ready), 32'd0);
        finish_done("race");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
